// File: rtl/reg_bank_pkg.sv
// Shared types and default sizing for the register-bank write arbiter.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_NREG  = 4;
  localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/reg_word.sv
// One WIDTH-bit storage word of the bank; loads D when EN is high, otherwise holds.
module reg_word #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  // Storage word with synchronous clear
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      Q <= '0;
    end else if (EN) begin
      Q <= D;
    end else begin
      Q <= Q;
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin write arbiter and sequencer for a shared bank of registers.
// One grant at a time: IDLE -> WRITE -> ACK, so one write per three cycles.
module reg_bank_arbiter
  import reg_bank_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int NREG  = DEF_NREG,
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = $clog2(NREG)
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [NREQ-1:0]            REQ,
  input  logic [NREQ*AW-1:0]         WADDR,
  input  logic [NREQ*WIDTH-1:0]      WDATA,
  output logic [NREQ-1:0]            ACK,
  output logic [$clog2(NREQ)-1:0]    GNT_ID,
  output logic                       BUSY,
  input  logic [AW-1:0]              RADDR,
  output logic [WIDTH-1:0]           RDATA,
  output logic [NREG*WIDTH-1:0]      Q_ALL
);

  localparam int IW = $clog2(NREQ);

  state_t            state_r;
  logic [IW-1:0]     ptr_r;
  logic [IW-1:0]     gnt_id_r;
  logic [AW-1:0]     held_addr_r;
  logic [WIDTH-1:0]  held_data_r;
  logic [NREQ-1:0]   ack_r;
  logic              busy_r;

  logic [IW-1:0]     winner_s;
  logic [IW-1:0]     next_ptr_s;
  logic [NREG-1:0]   wen_s;

  // First requester with REQ high, scanning upward from ptr with wrap-around
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                            input logic [IW-1:0]   ptr);
    logic [IW-1:0] win;
    logic          found;
    int            idx;
    win   = ptr;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        win   = IW'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  // Winner selection and the pointer that follows it
  always_comb begin
    winner_s = rr_pick(REQ, ptr_r);
    if (int'(winner_s) == NREQ - 1) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = winner_s + IW'(1);
    end
  end

  // Only the held address is enabled, and only during WRITE
  always_comb begin
    wen_s = '0;
    if (state_r == ST_WRITE) begin
      wen_s[held_addr_r] = 1'b1;
    end else begin
      wen_s = '0;
    end
  end

  // Sequencer: grant in IDLE, write in WRITE, acknowledge in ACK
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r     <= ST_IDLE;
      ptr_r       <= '0;
      gnt_id_r    <= '0;
      held_addr_r <= '0;
      held_data_r <= '0;
      ack_r       <= '0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ack_r <= '0;
          if (|REQ) begin
            gnt_id_r    <= winner_s;
            ptr_r       <= next_ptr_s;
            held_addr_r <= WADDR[int'(winner_s)*AW +: AW];
            held_data_r <= WDATA[int'(winner_s)*WIDTH +: WIDTH];
            busy_r      <= 1'b1;
            state_r     <= ST_WRITE;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          ack_r   <= NREQ'(1) << gnt_id_r;
          busy_r  <= 1'b1;
          state_r <= ST_ACK;
        end
        ST_ACK: begin
          ack_r   <= '0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          ack_r   <= '0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NREG; k++) begin : g_bank
    reg_word #(
      .WIDTH (WIDTH)
    ) u_word (
      .CLK   (CLK),
      .RST_N (RST_N),
      .EN    (wen_s[k]),
      .D     (held_data_r),
      .Q     (Q_ALL[k*WIDTH +: WIDTH])
    );
  end

  // Read port is a plain mux on the bank outputs
  always_comb begin
    RDATA = Q_ALL[int'(RADDR)*WIDTH +: WIDTH];
  end

  assign ACK    = ack_r;
  assign GNT_ID = gnt_id_r;
  assign BUSY   = busy_r;

endmodule
